// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions used by the fetch stage and the decode controller.
//   fetch_state_t : fetch FSM encoding
//   NOP_INSTR     : canonical NOP (addi x0,x0,0)
//   OPC_*         : major opcodes
//   *_MSB/*_LSB   : instruction field positions
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int OPCODE_MSB = 6;
  localparam int OPCODE_LSB = 0;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT7_MSB = 31;
  localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage.
// Holds the PC, fetches one word per instruction over a req/ack memory port
// (variable latency), presents it to decode with a valid/ready handshake and
// selects the next PC (sequential or branch target). A misaligned taken
// target parks the block in FAULT until reset.
//   clk, reset            : clock, async active-high reset
//   imem_req/addr         : fetch request and address (= pc)
//   imem_rdata/ack        : one-cycle response
//   instr_ready           : decode consumed the instruction
//   pcsrc, branch_target  : next-PC select, sampled only on consume
//   instr, instr_valid, pc: instruction register, valid flag, its address
//   opcode/funct3/funct7  : field slices of instr
//   fault                 : sticky misaligned-target flag
//   retired               : consumed instruction count (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        fault,
  output logic [31:0] retired
);
  import riscv_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  retired_q, retired_d;
  logic [31:0]  next_pc;
  logic         misaligned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Natural 32-bit wrap on the sequential path.
  assign next_pc    = pcsrc ? branch_target : pc_q + 32'd4;
  assign misaligned = pcsrc && (branch_target[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          // A bad target is not loaded into pc, so pc still names the
          // instruction that caused the fault.
          if (misaligned) begin
            state_d = FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  assign imem_req    = (state_q == REQ);
  assign instr_valid = (state_q == VALID);
  assign fault       = (state_q == FAULT);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign retired     = retired_q;
  assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign funct3      = instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign funct7      = instr_q[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        instr_ready;
  logic        pcsrc;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        fault;
  logic [31:0] retired;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic prev_valid = 1'b0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr_ready(instr_ready), .pcsrc(pcsrc), .branch_target(branch_target),
    .instr(instr), .instr_valid(instr_valid), .pc(pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .fault(fault), .retired(retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every new instruction presented to decode is checked against the
  // oldest scoreboard entry.
  always @(negedge clk) begin
    if (mon_en && instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_pc", pc, e.pc);
        chk("mon_instr", instr, e.instr);
        chk("mon_opcode", {25'd0, opcode}, {25'd0, e.opc});
        chk("mon_funct3", {29'd0, funct3}, {29'd0, e.f3});
        chk("mon_funct7", {25'd0, funct7}, {25'd0, e.f7});
      end
    end
    prev_valid <= instr_valid;
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"}, pc, 32'h100);
    chk({tag, "_instr"}, instr, 32'h13);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
  endtask

  // Wait (at negedges) for imem_req, check address, hold the request w cycles
  // with rdata noise, then ack with word. Expected entry goes to scoreboard.
  task automatic fetch(input int w, input logic [31:0] addr, input logic [31:0] word,
                       input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    int t = 0;
    exp_t e;
    while (imem_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (imem_req !== 1'b1) begin chk("req_timeout", 32'd0, 32'd1); return; end
    chk("fetch_addr", imem_addr, addr);
    e.pc = addr; e.instr = word; e.opc = opc; e.f3 = f3; e.f7 = f7;
    sb.push_back(e);
    for (int i = 0; i < w; i++) begin
      imem_rdata = $urandom;
      imem_ack   = 1'b0;
      @(negedge clk);
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, addr);
      chk("no_early_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_rdata = word;
    imem_ack   = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
  endtask

  // Consume in the current VALID cycle, then check the following cycle.
  task automatic consume(input logic src, input logic [31:0] tgt,
                         input logic [31:0] exp_addr, input logic [31:0] exp_ret);
    instr_ready = 1'b1; pcsrc = src; branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0; pcsrc = 1'b0; branch_target = 32'hDEAD_BEEF;
    chk("next_req", {31'd0, imem_req}, 32'd1);
    chk("next_addr", imem_addr, exp_addr);
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("retired", retired, exp_ret);
  endtask

  initial begin
    reset = 1'b1; imem_rdata = '0; imem_ack = 1'b0; instr_ready = 1'b0;
    pcsrc = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    mon_en = 1'b1;
    reset = 1'b0;
    // IDLE cycle: stray ack is ignored.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_ack_instr", instr, 32'h13);

    // addi x1,x0,10 at 0x100, w=0
    fetch(0, 32'h100, 32'h00A0_0093, 7'h13, 3'h0, 7'h00);

    // Stall 5 cycles with a stray ack; everything frozen.
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 2); imem_rdata = 32'hBAD0_0002;
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h00A0_0093);
      chk("stall_pc", pc, 32'h100);
      chk("stall_ret", retired, 32'd0);
    end
    imem_ack = 1'b0;
    consume(1'b0, 32'h0, 32'h104, 32'd1);

    // sub x10,x10,x11 at 0x104, w=3 with noise; then branch to 0x200
    fetch(3, 32'h104, 32'h40B5_0533, 7'h33, 3'h0, 7'h20);
    consume(1'b1, 32'h200, 32'h200, 32'd2);

    // sw x6,0(x5) at 0x200, w=1; branch to top of address space
    fetch(1, 32'h200, 32'h0062_A023, 7'h23, 3'h2, 7'h00);
    consume(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd3);

    // beq at 0xFFFFFFFC; sequential wraps to 0
    fetch(0, 32'hFFFF_FFFC, 32'h00B5_0463, 7'h63, 3'h0, 7'h00);
    consume(1'b0, 32'h0, 32'h0, 32'd4);

    // addi x11,x11,12 at 0, w=2; misaligned taken branch -> FAULT
    fetch(2, 32'h0, 32'h00C5_8593, 7'h13, 3'h0, 7'h00);
    instr_ready = 1'b1; pcsrc = 1'b1; branch_target = 32'h202;
    @(negedge clk);
    instr_ready = 1'b0; pcsrc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fault_flag", {31'd0, fault}, 32'd1);
      chk("fault_req", {31'd0, imem_req}, 32'd0);
      chk("fault_valid", {31'd0, instr_valid}, 32'd0);
      chk("fault_pc", pc, 32'h0);
      chk("fault_ret", retired, 32'd5);
      imem_ack = 1'b1; instr_ready = 1'b1; pcsrc = 1'b1; branch_target = 32'h300;
      @(negedge clk);
      imem_ack = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0;
    end

    // Reset clears fault.
    reset = 1'b1;
    #1;
    check_reset_vals("fault_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h100);

    // Reset asserted mid-REQ, asynchronously.
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    // Ack present in the cycle reset deasserts: block is in IDLE, ignored.
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("post_rst_instr", instr, 32'h13);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);

    // Normal fetch after reset: lw x5,8(x2) at 0x100
    fetch(1, 32'h100, 32'h0081_2283, 7'h03, 3'h2, 7'h00);
    consume(1'b0, 32'h0, 32'h104, 32'd1);

    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
